// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multicycle adder: FSM encoding, slice-count
// helper, parameter legality check and the one-bit full-adder cell.
package multicycle_adder_pkg;

  // Controller states, fixed 2-bit encoding so debug taps stay stable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of SLICE-wide passes needed to cover WIDTH bits.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slicing is only meaningful when SLICE evenly tiles WIDTH.
  function automatic bit slicing_legal(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

  // Full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
    return {co, s};
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result bus of the multicycle adder.
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// clk edge where valid && ready are both 1. Once valid is raised the source
// holds it and its payload unchanged until the transfer; ready may be raised
// or dropped at any time and never depends combinationally on a future valid.
// The start channel carries {a, b, carryin, sub}; the result channel carries
// {sum, carryout, overflow}.
interface multicycle_adder_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             sub;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  // Producer/consumer side.
  modport master (
    output start_valid, a, b, carryin, sub, result_ready,
    input  start_ready, result_valid, sum, carryout, overflow
  );

  // Adder side.
  modport slave (
    input  start_valid, a, b, carryin, sub, result_ready,
    output start_ready, result_valid, sum, carryout, overflow
  );
endinterface

// File: rtl/multicycle_adder_slice.sv
// Combinational SLICE-bit ripple adder built from full-adder cells.
// c_msb is the carry into the slice's top bit, needed for signed overflow.
module multicycle_adder_slice
  import multicycle_adder_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  // Ripple chain, one full-adder cell per bit.
  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign {c[i+1], s[i]} = full_add(a_s[i], b_s[i], c[i]);
  end

  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder/subtractor that adds SLICE bits per clock, carrying
// between cycles through a carry register. One operation in flight at a time.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_adder_if.slave   bus,
  output state_t              dbg_state
);

  localparam int              NSLICE     = nslice(WIDTH, SLICE);
  localparam int              KW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0]   K_LAST     = KW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  if (!slicing_legal(WIDTH, SLICE)) begin : g_bad_params
    $error("multicycle_adder: WIDTH (%0d) must be a positive multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  state_t           state_q;
  state_t           state_n;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      sh;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] s_s;
  logic             cout_s;
  logic             cmsb_s;
  logic [WIDTH-1:0] sum_n;
  logic             last;

  // Select slice k of the captured operands.
  always_comb begin
    sh   = 32'(k_q) * 32'(SLICE);
    a_s  = SLICE'(a_q >> sh);
    b_s  = SLICE'(b_q >> sh);
    last = (k_q == K_LAST);
  end

  multicycle_adder_slice #(.SLICE(SLICE)) u_slice (
    .a_s   (a_s),
    .b_s   (b_s),
    .cin   (carry_q),
    .s     (s_s),
    .cout  (cout_s),
    .c_msb (cmsb_s)
  );

  // Merge the fresh slice result into sum[k*SLICE +: SLICE].
  always_comb begin
    sum_n = (sum_q & ~(SLICE_MASK << sh)) | (WIDTH'(s_s) << sh);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n          = state_q;
    bus.start_ready  = 1'b0;
    bus.result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) state_n = ADD;
      end
      ADD: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and datapath; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      unique case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            // Subtract is a + ~b + 1, so invert b and force carry-in.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.carryin;
            k_q     <= '0;
          end
        end
        ADD: begin
          sum_q   <= sum_n;
          carry_q <= cout_s;
          if (last) begin
            cout_q <= cout_s;
            ovf_q  <= cmsb_s ^ cout_s;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = sum_q;
  assign bus.carryout = cout_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state_q;

endmodule
